// File: rtl/bram_xfer_cmd_scheduler.sv
// Command front-end for the AXI BRAM transfer FSM: validates 64-bit commands,
// issues a one-cycle instruction strobe, watches for completion and reports status.
module bram_xfer_cmd_scheduler #(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int WR_BRAM_MAX    = 31,
  parameter int RD_BRAM_MAX    = 15
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [63:0] cmd_data,
  input  logic        xfer_done,
  input  logic        err_clear,
  output logic [7:0]  instr_code,
  output logic [4:0]  wr_bram_start,
  output logic [4:0]  wr_bram_end,
  output logic [3:0]  rd_bram_start,
  output logic [3:0]  rd_bram_end,
  output logic [15:0] wr_addr_start,
  output logic [15:0] wr_addr_count,
  output logic [15:0] rd_addr_start,
  output logic [15:0] rd_addr_count,
  output logic        busy,
  output logic        cmd_done,
  output logic [1:0]  err_code,
  output logic [15:0] cmd_count
);

  // state     | meaning
  // S_IDLE    | waiting for a command (accepts only when no sticky error)
  // S_CHECK   | validating the latched command
  // S_ISSUE   | one-cycle instruction strobe to the transfer FSM
  // S_WAIT    | waiting for xfer_done under watchdog
  // S_REPORT  | cmd_done pulse, status/counter update
  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_REPORT
  } state_t;

  localparam int            TW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [5:0]    WR_MAX  = 6'(WR_BRAM_MAX);
  localparam logic [5:0]    RD_MAX  = 6'(RD_BRAM_MAX);

  localparam logic [7:0] OP_WR = 8'h01;
  localparam logic [7:0] OP_RD = 8'h02;

  localparam logic [1:0] E_NONE  = 2'd0;
  localparam logic [1:0] E_OPC   = 2'd1;
  localparam logic [1:0] E_RANGE = 2'd2;
  localparam logic [1:0] E_TMO   = 2'd3;

  state_t        state, state_nxt;
  logic [63:0]   cmd_q;
  logic [TW-1:0] to_cnt;
  logic [1:0]    res_err;

  logic [7:0]  opcode;
  logic [4:0]  bram_start, bram_end;
  logic [15:0] addr_start, addr_count;
  logic        is_wr, is_rd, op_bad, range_bad, timeout_hit, accept;
  logic        unused_cmd_bits;

  assign opcode     = cmd_q[63:56];
  assign bram_start = cmd_q[52:48];
  assign bram_end   = cmd_q[44:40];
  assign addr_start = cmd_q[31:16];
  assign addr_count = cmd_q[15:0];
  assign unused_cmd_bits = ^{cmd_q[55:53], cmd_q[47:45], cmd_q[39:32]};

  assign is_wr  = (opcode == OP_WR);
  assign is_rd  = (opcode == OP_RD);
  assign op_bad = !(is_wr || is_rd);
  assign range_bad = (bram_start > bram_end)
                   || (is_wr && ({1'b0, bram_end} > WR_MAX))
                   || (is_rd && ({1'b0, bram_end} > RD_MAX))
                   || (addr_count == 16'd0);

  assign timeout_hit = (to_cnt == '0);

  // Ready is gated by aresetn so every output reads 0 while reset is held.
  assign cmd_ready = aresetn && (state == S_IDLE) && (err_code == E_NONE);
  assign accept    = cmd_valid && cmd_ready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    instr_code = 8'h00;
    cmd_done   = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE:   if (accept) state_nxt = S_CHECK;
      S_CHECK:  state_nxt = (op_bad || range_bad) ? S_REPORT : S_ISSUE;
      S_ISSUE: begin
        instr_code = opcode;
        state_nxt  = S_WAIT;
      end
      S_WAIT:   if (xfer_done || timeout_hit) state_nxt = S_REPORT;
      S_REPORT: begin
        cmd_done  = 1'b1;
        state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cmd_q         <= '0;
      to_cnt        <= '0;
      res_err       <= E_NONE;
      err_code      <= E_NONE;
      cmd_count     <= '0;
      wr_bram_start <= '0;
      wr_bram_end   <= '0;
      rd_bram_start <= '0;
      rd_bram_end   <= '0;
      wr_addr_start <= '0;
      wr_addr_count <= '0;
      rd_addr_start <= '0;
      rd_addr_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept)    cmd_q    <= cmd_data;
          if (err_clear) err_code <= E_NONE;
        end
        S_CHECK: begin
          if (op_bad) begin
            res_err <= E_OPC;
          end else if (range_bad) begin
            res_err <= E_RANGE;
          end else begin
            res_err <= E_NONE;
            if (is_wr) begin
              wr_bram_start <= bram_start;
              wr_bram_end   <= bram_end;
              wr_addr_start <= addr_start;
              wr_addr_count <= addr_count;
            end else begin
              rd_bram_start <= bram_start[3:0];
              rd_bram_end   <= bram_end[3:0];
              rd_addr_start <= addr_start;
              rd_addr_count <= addr_count;
            end
          end
        end
        S_ISSUE: to_cnt <= TO_LOAD;
        S_WAIT: begin
          // Completion takes priority over a watchdog expiry in the same cycle.
          if (xfer_done)        res_err <= E_NONE;
          else if (timeout_hit) res_err <= E_TMO;
          else                  to_cnt  <= to_cnt - TW'(1);
        end
        S_REPORT: begin
          if (res_err == E_NONE)      cmd_count <= cmd_count + 16'd1;
          else if (err_code == E_NONE) err_code <= res_err;
          res_err       <= E_NONE;
          to_cnt        <= '0;
          wr_bram_start <= '0;
          wr_bram_end   <= '0;
          rd_bram_start <= '0;
          rd_bram_end   <= '0;
          wr_addr_start <= '0;
          wr_addr_count <= '0;
          rd_addr_start <= '0;
          rd_addr_count <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/bram_xfer_cmd_scheduler.md
Name: bram_xfer_cmd_scheduler

Overview:
- Command front-end for the AXI BRAM transfer FSM.
- Accepts 64-bit transfer commands over a valid/ready handshake and validates opcode and ranges.
- Issues each command as a one-cycle instruction strobe with stable parameters, then waits for completion with a watchdog.
- Reports per-command status and sticky errors to the host-side control logic.

Parameters:
- TIMEOUT_CYCLES, 65535: maximum cycles allowed in WAIT_DONE before a timeout error (must be >= 2).
- WR_BRAM_MAX, 31: highest legal write BRAM index.
- RD_BRAM_MAX, 15: highest legal read BRAM index.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command word valid.
- cmd_ready  out  1  scheduler can accept a command.
- cmd_data  in  64  command word: [63:56] opcode, [52:48] bram_start, [44:40] bram_end, [31:16] addr_start, [15:0] addr_count; other bits ignored.
- xfer_done  in  1  one-cycle pulse from the transfer FSM when it enters DONE.
- err_clear  in  1  clears the sticky error and un-halts.
- instr_code  out  8  instruction to the transfer FSM (0x01 write, 0x02 read, 0x00 none).
- wr_bram_start, wr_bram_end  out  5 each  write BRAM range.
- rd_bram_start, rd_bram_end  out  4 each  read BRAM range.
- wr_addr_start, wr_addr_count, rd_addr_start, rd_addr_count  out  16 each  address window.
- busy  out  1  high in any state other than IDLE.
- cmd_done  out  1  one-cycle pulse per finished or rejected command.
- err_code  out  2  sticky: 0 none, 1 illegal opcode, 2 range error, 3 timeout.
- cmd_count  out  16  number of successfully completed commands; wraps at 0xFFFF -> 0.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; all outputs 0; timeout counter 0; latched command 0.
- States:
  - IDLE -> CHECK: on cmd_valid && cmd_ready; the full cmd_data word is latched that cycle.
  - CHECK -> REPORT, err 1: opcode not 0x01 and not 0x02. Opcode 0x00 is also illegal.
  - CHECK -> REPORT, err 2: bram_start > bram_end, or bram_end > WR_BRAM_MAX (write), or bram_end > RD_BRAM_MAX (read), or addr_count == 0.
  - CHECK -> ISSUE: otherwise. Parameter outputs are loaded from the latch here.
    - Write commands drive only the wr_* outputs; read commands drive only the rd_* outputs; the unused group is 0.
  - ISSUE -> WAIT_DONE:
    - instr_code equals the opcode for exactly this one cycle and is 0x00 in every other state.
    - This prevents the transfer FSM from re-triggering when it returns to IDLE.
  - WAIT_DONE -> REPORT on xfer_done, success.
    - The timeout counter clears on entry and increments every cycle.
    - When the counter reaches TIMEOUT_CYCLES-1 without xfer_done: go to REPORT with err 3.
    - xfer_done and timeout in the same cycle: done wins, no error.
  - REPORT -> IDLE: cmd_done=1 for one cycle.
    - On success, cmd_count increments.
    - On error, err_code is set if currently 0; the first error is kept, later errors do not overwrite it.
- Parameter outputs:
  - Held stable from CHECK exit through REPORT.
  - Cleared to 0 on return to IDLE.
- cmd_ready:
  - Equals (state==IDLE) && (err_code==0). After any error the scheduler halts and accepts no commands.
  - err_clear zeroes err_code in IDLE, and cmd_ready rises the next cycle.
  - err_clear in any other state is ignored.
- xfer_done outside WAIT_DONE is ignored and sets no error.
- Latency:
  - Accept at cycle T; instr_code strobe at T+2.
  - xfer_done at cycle D gives cmd_done at D+1; IDLE at D+2.
- Reset mid-operation: immediate return to IDLE with all outputs 0. The transfer FSM is reset by the same aresetn.

Test Plan:
- Write cmd: opcode 0x01, bram 2..5, addr 0x0010, count 0x0040 -> instr_code=0x01 for one cycle at T+2; wr_bram_start=2, wr_bram_end=5, wr_addr_count=0x0040 stable until REPORT; rd_* = 0. xfer_done at T+50 -> cmd_done at T+51, cmd_count=1.
- Read cmd: opcode 0x02, bram 0..15, count 8 -> rd_bram_end=15, instr_code=0x02 one cycle; then a second command offered while busy -> cmd_ready stays 0 until IDLE.
- Illegal: opcode 0x07 -> cmd_done at T+2, err_code=1, no instr_code strobe, cmd_ready=0. Then err_clear -> cmd_ready=1 next cycle.
- Range: read with bram_end=16 -> err 2. Write with start=6, end=3 -> err 2. addr_count=0 -> err 2. In all cases no instr_code strobe.
- Timeout with TIMEOUT_CYCLES=8 and no xfer_done -> err_code=3 after 8 cycles in WAIT_DONE. Repeat with xfer_done on cycle 8 -> success, err_code=0.
- aresetn asserted in WAIT_DONE -> all outputs 0 asynchronously; after release, a new write cmd completes normally with cmd_count=1.
